// File: rtl/ex_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Radix-2 restoring divide, one quotient bit per cycle, with pipeline hold request.
module ex_div (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rd_addr_in,
    input  logic        flush,
    output logic [31:0] result,
    output logic        ready,
    output logic [4:0]  rd_addr_out,
    output logic        busy,
    output logic        hold_req
);

    // state | meaning
    // IDLE  | waiting for a divide request
    // CALC  | producing one quotient bit per cycle
    // DONE  | result valid, ready pulse, pipeline released
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [31:0] rem_q, quo_q, dvsr_q;
    logic        op_rem, neg_quo, neg_rem;
    logic [4:0]  rd_q;
    logic [31:0] res_new, result_q;
    logic [4:0]  rd_out_q;
    logic        ready_q;

    logic        is_signed, accept;
    logic [31:0] abs_a, abs_b;
    logic [32:0] rem_sh, diff;
    logic        no_borrow;
    logic [31:0] rem_step, quo_step, final_val;

    assign is_signed = ~funct3[0];
    assign accept    = (state == IDLE) & start & funct3[2] & ~flush;
    assign abs_a     = (is_signed & dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign abs_b     = (is_signed & divisor[31])  ? (~divisor + 32'd1)  : divisor;

    assign rem_sh    = {rem_q, quo_q[31]};
    assign diff      = rem_sh - {1'b0, dvsr_q};
    assign no_borrow = ~diff[32];
    assign rem_step  = no_borrow ? diff[31:0] : rem_sh[31:0];
    assign quo_step  = {quo_q[30:0], no_borrow};
    assign final_val = op_rem ? (neg_rem ? (~rem_step + 32'd1) : rem_step)
                              : (neg_quo ? (~quo_step + 32'd1) : quo_step);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (divisor == 32'd0) ? DONE : CALC;
            CALC: begin
                if (flush)               state_nxt = IDLE;
                else if (count == 5'd31) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count    <= 5'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            op_rem   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            rd_q     <= 5'd0;
            res_new  <= 32'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_rem  <= funct3[1];
                    neg_quo <= is_signed & (dividend[31] ^ divisor[31]);
                    neg_rem <= is_signed & dividend[31];
                    dvsr_q  <= abs_b;
                    rem_q   <= 32'd0;
                    quo_q   <= abs_a;
                    count   <= 5'd0;
                    rd_q    <= rd_addr_in;
                    // Divide by zero skips CALC; REM returns the raw dividend.
                    if (divisor == 32'd0) begin
                        res_new <= funct3[1] ? dividend : 32'hFFFF_FFFF;
                        ready_q <= 1'b1;
                    end
                end
                CALC: if (!flush) begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        res_new <= final_val;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    if (!flush) begin
                        result_q <= res_new;
                        rd_out_q <= rd_q;
                    end
                end
                default: ready_q <= 1'b0;
            endcase
        end
    end

    // A flush coinciding with DONE cancels the completion; old result stays visible.
    assign ready       = ready_q & ~flush;
    assign result      = ready ? res_new : result_q;
    assign rd_addr_out = ready ? rd_q : rd_out_q;
    assign busy        = (state != IDLE);
    assign hold_req    = accept | ((state == CALC) & ~flush);

endmodule

// File: tb/tb_ex_div.sv
// Directed testbench for ex_div: latency, hold window, signed/unsigned results,
// divide by zero, flush, busy-ignore and asynchronous reset.
module tb_ex_div;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_addr_in;
    logic        flush;
    logic [31:0] result;
    logic        ready;
    logic [4:0]  rd_addr_out;
    logic        busy;
    logic        hold_req;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    ex_div dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .funct3     (funct3),
        .dividend   (dividend),
        .divisor    (divisor),
        .rd_addr_in (rd_addr_in),
        .flush      (flush),
        .result     (result),
        .ready      (ready),
        .rd_addr_out(rd_addr_out),
        .busy       (busy),
        .hold_req   (hold_req)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Drives one start request in cycle T; returns after the T->T+1 edge.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic hold0);
        @(negedge sys_clk);
        start = 1'b1; funct3 = f3; dividend = a; divisor = b; rd_addr_in = rd;
        #1 hold0 = hold_req;
        @(posedge sys_clk);
        #1 start = 1'b0;
    endtask

    // Waits up to 40 cycles for ready; lat is cycles after T+offset (0 = timeout).
    task automatic wait_ready(output int lat, output int holds, output logic hold_at_rdy,
                              output logic [31:0] res, output logic [4:0] rd);
        lat = 0; holds = 0; hold_at_rdy = 1'bx; res = 'x; rd = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sys_clk);
            if (ready === 1'b1) begin
                lat = k; hold_at_rdy = hold_req; res = result; rd = rd_addr_out;
                break;
            end
            if (hold_req === 1'b1) holds++;
        end
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; dividend = '0; divisor = '0;
        rd_addr_in = '0; flush = 1'b0;
        #12;
        chk_cnt++;
        if ({result, ready, rd_addr_out, busy, hold_req} !== 40'd0)
            $display("FAIL reset_outputs: got res=%h rdy=%b rd=%0d busy=%b hold=%b, want all 0",
                     result, ready, rd_addr_out, busy, hold_req);
        else pass_cnt++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_divu_basic;
        logic h0, hr; int lat, holds; logic [31:0] res; logic [4:0] rd;
        launch(F_DIVU, 32'd100, 32'd7, 5'd5, h0);
        wait_ready(lat, holds, hr, res, rd);
        chk_cnt++;
        if (lat !== 33) $display("FAIL divu_latency: got %0d, want 33", lat); else pass_cnt++;
        chk_cnt++;
        if (holds + int'(h0) !== 33) $display("FAIL divu_hold_cycles: got %0d, want 33", holds + int'(h0));
        else pass_cnt++;
        chk_cnt++;
        if (res !== 32'd14) $display("FAIL divu_result: got %h, want %h", res, 32'd14); else pass_cnt++;
        chk_cnt++;
        if (rd !== 5'd5) $display("FAIL divu_rd: got %0d, want 5", rd); else pass_cnt++;
        chk_cnt++;
        if (hr !== 1'b0) $display("FAIL divu_hold_at_ready: got %b, want 0", hr); else pass_cnt++;
        @(negedge sys_clk);
        chk_cnt++;
        if ({ready, busy} !== 2'b00 || result !== 32'd14)
            $display("FAIL divu_after: got rdy=%b busy=%b res=%h, want 0 0 0000000e", ready, busy, result);
        else pass_cnt++;
    endtask

    task automatic test_signed;
        logic [2:0]  f3 [5] = '{F_DIV, F_REM, F_REMU, F_DIV, F_REM};
        logic [31:0] a  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [5] = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd0};
        logic h0, hr; int lat, holds; logic [31:0] res; logic [4:0] rd;
        for (int i = 0; i < 5; i++) begin
            launch(f3[i], a[i], b[i], 5'(i + 10), h0);
            wait_ready(lat, holds, hr, res, rd);
            chk_cnt++;
            if (lat !== 33 || res !== e[i] || rd !== 5'(i + 10))
                $display("FAIL signed_vec%0d: got lat=%0d res=%h rd=%0d, want lat=33 res=%h rd=%0d",
                         i, lat, res, rd, e[i], i + 10);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero;
        logic [2:0]  f3 [4] = '{F_DIV, F_REM, F_DIVU, F_REMU};
        logic [31:0] e  [4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_1234};
        logic h0, hr; int lat, holds; logic [31:0] res; logic [4:0] rd;
        for (int i = 0; i < 4; i++) begin
            launch(f3[i], 32'h0000_1234, 32'd0, 5'd7, h0);
            wait_ready(lat, holds, hr, res, rd);
            chk_cnt++;
            if (lat !== 1 || res !== e[i] || holds + int'(h0) !== 1 || hr !== 1'b0)
                $display("FAIL divzero_vec%0d: got lat=%0d res=%h holds=%0d, want lat=1 res=%h holds=1",
                         i, lat, res, holds + int'(h0), e[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic h0, hr; int lat, holds; logic [31:0] res; logic [4:0] rd;
        launch(F_DIV, 32'd55, 32'd0, 5'd1, h0);
        wait_ready(lat, holds, hr, res, rd);
        // Next launch samples start at T+2.
        launch(F_DIVU, 32'd9, 32'd3, 5'd2, h0);
        chk_cnt++;
        if (h0 !== 1'b1) $display("FAIL b2b_accept_hold: got %b, want 1", h0); else pass_cnt++;
        wait_ready(lat, holds, hr, res, rd);
        chk_cnt++;
        if (lat !== 33 || res !== 32'd3 || rd !== 5'd2)
            $display("FAIL b2b_result: got lat=%0d res=%h rd=%0d, want 33 00000003 2", lat, res, rd);
        else pass_cnt++;
    endtask

    task automatic test_ignored_start;
        logic h0;
        launch(3'b001, 32'd10, 32'd2, 5'd3, h0);
        chk_cnt++;
        if (h0 !== 1'b0 || busy !== 1'b0)
            $display("FAIL non_divide_start: got hold=%b busy=%b, want 0 0", h0, busy);
        else pass_cnt++;
        @(negedge sys_clk);
        flush = 1'b1;
        launch(F_DIVU, 32'd10, 32'd2, 5'd3, h0);
        flush = 1'b0;
        chk_cnt++;
        if (h0 !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_beats_start: got hold=%b busy=%b, want 0 0", h0, busy);
        else pass_cnt++;
    endtask

    task automatic test_flush_restart;
        logic h0, hr; int lat, holds; logic [31:0] res; logic [4:0] rd; logic saw_ready;
        saw_ready = 1'b0;
        launch(F_DIVU, 32'd100, 32'd7, 5'd4, h0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge sys_clk);
            if (ready) saw_ready = 1'b1;
        end
        @(posedge sys_clk);
        #1 flush = 1'b1;
        #1;
        chk_cnt++;
        if (hold_req !== 1'b0 || ready !== 1'b0)
            $display("FAIL flush_hold: got hold=%b rdy=%b at T+10, want 0 0", hold_req, ready);
        else pass_cnt++;
        @(posedge sys_clk);
        #1 flush = 1'b0;
        chk_cnt++;
        if (busy !== 1'b0 || ready !== 1'b0 || saw_ready)
            $display("FAIL flush_idle: got busy=%b rdy=%b early_ready=%b at T+11, want 0 0 0",
                     busy, ready, saw_ready);
        else pass_cnt++;
        launch(F_DIVU, 32'd9, 32'd3, 5'd6, h0);
        wait_ready(lat, holds, hr, res, rd);
        chk_cnt++;
        if (lat !== 33 || res !== 32'd3 || rd !== 5'd6)
            $display("FAIL flush_restart: got lat=%0d res=%h rd=%0d, want 33 00000003 6", lat, res, rd);
        else pass_cnt++;
    endtask

    task automatic test_busy_ignore;
        logic h0, hr; int lat, holds; logic [31:0] res; logic [4:0] rd;
        launch(F_DIVU, 32'd100, 32'd7, 5'd9, h0);
        for (int k = 1; k <= 4; k++) @(negedge sys_clk);
        @(negedge sys_clk);
        start = 1'b1; funct3 = F_DIVU; dividend = 32'd50; divisor = 32'd5; rd_addr_in = 5'd3;
        @(posedge sys_clk);
        #1 start = 1'b0;
        wait_ready(lat, holds, hr, res, rd);
        chk_cnt++;
        if (lat !== 28 || res !== 32'd14 || rd !== 5'd9)
            $display("FAIL busy_ignore: got lat=%0d res=%h rd=%0d, want 28 0000000e 9", lat, res, rd);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic h0; logic saw_ready;
        saw_ready = 1'b0;
        launch(F_DIV, 32'd1000, 32'd10, 5'd12, h0);
        for (int k = 1; k <= 19; k++) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({result, ready, rd_addr_out, busy, hold_req} !== 40'd0)
            $display("FAIL reset_mid: got res=%h rdy=%b rd=%0d busy=%b hold=%b, want all 0",
                     result, ready, rd_addr_out, busy, hold_req);
        else pass_cnt++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (ready !== 1'b0 || busy !== 1'b0) saw_ready = 1'b1;
        end
        chk_cnt++;
        if (saw_ready) $display("FAIL reset_no_ready: activity seen after reset release, want none");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_back_to_back();
        test_ignored_start();
        test_flush_restart();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle RV32M divider in the EX stage of the 3-stage core, downstream of the ID/EX pipeline register. It executes DIV/DIVU/REM/REMU with a radix-2 restoring algorithm, one quotient bit per cycle. While it works it drives a hold request back toward the front of the pipeline, stalling IF/ID/EX, and releases the hold in the cycle its result is valid.

## Interface

- No parameters; datapath is fixed at 32 bits.
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request from EX decode; sampled only in IDLE.
- funct3  in  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx means not a divide, so start is ignored.
- dividend  in  32  rs1 value (op1).
- divisor  in  32  rs2 value (op2).
- rd_addr_in  in  5  destination register, captured at start.
- flush  in  1  jump/branch cancel from EX; aborts any operation.
- result  out  32  quotient or remainder; registered.
- ready  out  1  one-cycle pulse, result valid; registered.
- rd_addr_out  out  5  captured rd, valid with ready; registered.
- busy  out  1  high in any state other than IDLE.
- hold_req  out  1  pipeline stall request; combinational.

## Operation

- States: IDLE, CALC, DONE.
- IDLE: on start=1, funct3[2]=1 and flush=0, capture the operation, |dividend|, |divisor|, the sign flags and rd_addr_in.
  - divisor==0 goes directly to DONE.
  - Otherwise go to CALC with count=0, remainder=0, shift register=|dividend|.
- CALC, each cycle: shift {rem, quo} left by 1 bit and trial-subtract |divisor|.
  - If no borrow, keep the difference and set the quotient LSB to 1.
  - After count==31 the state moves to DONE.
- DONE: register the result, pulse ready=1 for one cycle, return to IDLE.
- Sign handling for DIV/REM only; DIVU/REMU use the raw operands.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Absolute value is computed as an unsigned 32-bit two's-complement, so -2^31 maps to 0x80000000.
- Divide by zero:
  - DIV/DIVU give 0xFFFFFFFF.
  - REM/REMU give the original dividend.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF:
  - quotient 0x80000000, REM 0. This falls out of the algorithm; no special-case state is needed.
- start while busy is ignored; operands are not re-sampled.
- flush in CALC or DONE:
  - next state is IDLE;
  - ready is not pulsed, and ready is forced to 0 if DONE coincides with flush;
  - result keeps its previous value.
- flush and start in the same IDLE cycle: flush wins and no operation starts.

## Timing

- Reset values: result=0, ready=0, rd_addr_out=0, busy=0, state=IDLE, count=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately and asynchronously, and outputs go to their reset values.
- hold_req = (IDLE & start & funct3[2] & ~flush) | (CALC & ~flush).
  - hold_req is low in DONE, so the pipeline advances in the same cycle result and ready are valid.
- For a start accepted at cycle T (T = the cycle the start request is sampled in IDLE):
  - Normal operation: CALC in T+1..T+32, ready=1 at T+33, IDLE at T+34. hold_req is high T..T+32, 33 cycles.
  - Divide by zero: DONE in T+1 with ready=1. hold_req is high only at T.
  - A new start can be accepted at T+34, or at T+2 after divide by zero.
- ready, result and rd_addr_out are valid together for exactly one cycle. result and rd_addr_out hold their values afterward until the next completion.

## Test plan

- DIVU, dividend=100, divisor=7, rd=5, start at T -> hold_req high T..T+32; at T+33 ready=1, result=14, rd_addr_out=5, hold_req=0.
- DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF. REMU 0xFFFFFFF9%2 -> 1. Each is ready at T+33.
- Divide by zero, dividend=0x1234:
  - DIV -> 0xFFFFFFFF, ready at T+1;
  - REM -> 0x1234, ready at T+1.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000 and REM -> 0, both at T+33.
- Flush and restart: flush at T+10 -> IDLE at T+11, no ready pulse, hold_req low from T+10. A new DIVU 9/3 started at T+11 gives result 3 with ready at T+44.
- Busy and reset:
  - start pulsed with different operands at T+5 is ignored, and the result matches the original operands;
  - separately, sys_rst_n asserted at T+20 -> all outputs 0 immediately, and no ready pulse after release.
